// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped, write-back, write-allocate data
// cache: field widths of the CPU byte address and the controller state type.
package data_cache_pkg;

  localparam int TAG_W      = 3;
  localparam int INDEX_W    = 3;
  localparam int OFFSET_W   = 2;
  localparam int BLOCK_W    = 32;
  localparam int NUM_BLOCKS = 1 << INDEX_W;
  localparam int CPU_ADDR_W = TAG_W + INDEX_W + OFFSET_W;
  localparam int MEM_ADDR_W = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FETCH     = 2'd2
  } cache_state_e;

endpackage

// File: rtl/data_cache_fsm.sv
// Miss-handling controller for data_cache: state register plus next-state
// and strobe decode.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req             CPU request present (READ | WRITE)
//   hit             addressed block is valid with a matching tag
//   victim_dirty    addressed block is valid and dirty (needs write-back)
//   mem_busywait    memory busy; a transfer completes on an edge where it is 0
//   state           current state (also used as a debug view)
//   busywait        CPU stall
//   mem_read        block-fetch strobe
//   mem_write       block write-back strobe
//   latch_miss      capture the missing address this cycle
//   wb_done         write-back completes at this edge
//   fill_done       fetch completes at this edge
module cache_fsm
  import data_cache_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic         hit,
  input  logic         victim_dirty,
  input  logic         mem_busywait,
  output cache_state_e state,
  output logic         busywait,
  output logic         mem_read,
  output logic         mem_write,
  output logic         latch_miss,
  output logic         wb_done,
  output logic         fill_done
);

  cache_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    busywait   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    latch_miss = 1'b0;
    wb_done    = 1'b0;
    fill_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && !hit) begin
          busywait   = 1'b1;
          latch_miss = 1'b1;
          state_d    = victim_dirty ? ST_WRITEBACK : ST_FETCH;
        end
      end
      ST_WRITEBACK: begin
        busywait  = 1'b1;
        mem_write = 1'b1;
        if (!mem_busywait) begin
          wb_done = 1'b1;
          // A request abandoned during write-back has no block to fetch.
          state_d = req ? ST_FETCH : ST_IDLE;
        end
      end
      ST_FETCH: begin
        busywait = 1'b1;
        mem_read = 1'b1;
        if (!mem_busywait) begin
          fill_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/data_cache.sv
// 8-block x 4-byte direct-mapped data cache, write-back and write-allocate.
// Holds the valid/dirty/tag/data arrays and the byte select; miss sequencing
// lives in cache_fsm.
//
// Ports:
//   CLK, RESET        clock, asynchronous active-low reset
//   READ, WRITE       CPU load/store request (level); both high acts as WRITE
//   ADDRESS           CPU byte address {tag[7:5], index[4:2], offset[1:0]}
//   WRITEDATA         CPU store byte
//   READDATA          load byte, 8'h00 whenever the address does not hit
//   BUSYWAIT          CPU stall
//   MEM_READ/WRITE    memory block read / write-back strobes
//   MEM_ADDRESS       memory block address {tag, index}
//   MEM_WRITEDATA     write-back block (byte0 in [7:0]), zero otherwise
//   MEM_READDATA      fetched block (byte0 in [7:0])
//   MEM_BUSYWAIT      memory busy
//   dbg_state         controller state, for observation only
//
// Handshakes: the CPU raises READ or WRITE and holds request, address and
// data until it sees BUSYWAIT low; that cycle is the completing one (read
// data valid, store committed on the following edge). Toward memory, a strobe
// is held with a stable address/data until an edge where MEM_BUSYWAIT is
// sampled low; that edge completes the transfer.
module data_cache
  import data_cache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [CPU_ADDR_W-1:0] ADDRESS,
  input  logic [7:0]            WRITEDATA,
  output logic [7:0]            READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT,
  output cache_state_e          dbg_state
);

  logic [TAG_W-1:0]    cpu_tag;
  logic [INDEX_W-1:0]  cpu_index;
  logic [OFFSET_W-1:0] cpu_offset;

  assign cpu_tag    = ADDRESS[OFFSET_W+INDEX_W +: TAG_W];
  assign cpu_index  = ADDRESS[OFFSET_W +: INDEX_W];
  assign cpu_offset = ADDRESS[OFFSET_W-1:0];

  logic [NUM_BLOCKS-1:0] valid_q, valid_d;
  logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_d  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_d [NUM_BLOCKS];

  // The miss address is captured when the miss is detected, so an abandoned
  // request (address no longer held) still completes at the right block.
  logic [TAG_W-1:0]      miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0]    miss_index_q, miss_index_d;

  logic         hit;
  logic         victim_dirty;
  logic         write_hit;
  logic         latch_miss;
  logic         wb_done;
  logic         fill_done;
  cache_state_e state;

  assign hit          = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);
  assign victim_dirty = valid_q[cpu_index] && dirty_q[cpu_index];
  // WRITE wins over READ, so a simultaneous READ is simply a store.
  assign write_hit    = (state == ST_IDLE) && WRITE && hit;

  cache_fsm u_fsm (
    .clk          (CLK),
    .rst_n        (RESET),
    .req          (READ | WRITE),
    .hit          (hit),
    .victim_dirty (victim_dirty),
    .mem_busywait (MEM_BUSYWAIT),
    .state        (state),
    .busywait     (BUSYWAIT),
    .mem_read     (MEM_READ),
    .mem_write    (MEM_WRITE),
    .latch_miss   (latch_miss),
    .wb_done      (wb_done),
    .fill_done    (fill_done)
  );

  assign dbg_state = state;

  always_comb begin
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    if (latch_miss) begin
      miss_tag_d   = cpu_tag;
      miss_index_d = cpu_index;
    end
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    // Once written back the block matches memory, so it is clean again.
    if (wb_done) begin
      dirty_d[miss_index_q] = 1'b0;
    end
    if (fill_done) begin
      data_d[miss_index_q]  = MEM_READDATA;
      tag_d[miss_index_q]   = miss_tag_q;
      valid_d[miss_index_q] = 1'b1;
      dirty_d[miss_index_q] = 1'b0;
    end
    if (write_hit) begin
      data_d[cpu_index][{cpu_offset, 3'b000} +: 8] = WRITEDATA;
      dirty_d[cpu_index] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q      <= '0;
      dirty_q      <= '0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
    end else begin
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
    end
  end

  // Tag and data contents are qualified by valid, so they carry no reset.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  always_comb begin
    READDATA = 8'h00;
    if (hit) begin
      READDATA = data_q[cpu_index][{cpu_offset, 3'b000} +: 8];
    end
  end

  always_comb begin
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state)
      ST_WRITEBACK: begin
        MEM_ADDRESS   = {tag_q[miss_index_q], miss_index_q};
        MEM_WRITEDATA = data_q[miss_index_q];
      end
      ST_FETCH: begin
        MEM_ADDRESS = {miss_tag_q, miss_index_q};
      end
      default: begin
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
      end
    endcase
  end

endmodule
